// File: rtl/boot_loader_ctrl.sv
// Boot-time image copier: streams HD words into instruction memory, holding the CPU until done.
// Optional running checksum of written words is enabled with `define BOOT_CHECKSUM_EN.
module boot_loader_ctrl #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 32,
   parameter int PROG_WORDS = 64,
   parameter int IMEM_BASE  = 0
) (
   input  logic              clk_auto,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] src_base,
   input  logic [ADDR_W-1:0] word_count,
   output logic [ADDR_W-1:0] hd_addr,
   input  logic [DATA_W-1:0] hd_data,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_data,
   output logic              imem_we,
`ifdef BOOT_CHECKSUM_EN
   output logic [DATA_W-1:0] checksum,
`endif
   output logic              cpu_hold,
   output logic              busy,
   output logic              done,
   output logic              len_err
);

   localparam logic [ADDR_W-1:0] PW_A   = ADDR_W'(PROG_WORDS);
   localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(IMEM_BASE);
   localparam logic [ADDR_W-1:0] ONE_A  = ADDR_W'(1);

   typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FINISH} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] n_q, n_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [ADDR_W-1:0] rd_idx_q, rd_idx_d;
   logic              v1_q, v1_d, v2_q, v2_d;
   logic [ADDR_W-1:0] idx1_q, idx1_d, idx2_q, idx2_d;
   logic [ADDR_W-1:0] hd_addr_q, hd_addr_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic [DATA_W-1:0] imem_data_q, imem_data_d;
   logic              imem_we_q, imem_we_d;
   logic              cpu_hold_q, cpu_hold_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              len_err_q, len_err_d;
`ifdef BOOT_CHECKSUM_EN
   logic [DATA_W-1:0] csum_q, csum_d;
`endif

   logic              too_long;
   logic [ADDR_W-1:0] n_sel;

   assign too_long = (word_count > PW_A);
   assign n_sel    = too_long ? PW_A : word_count;

   always_ff @(posedge clk_auto or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         n_q         <= '0;
         base_q      <= '0;
         rd_idx_q    <= '0;
         v1_q        <= 1'b0;
         v2_q        <= 1'b0;
         idx1_q      <= '0;
         idx2_q      <= '0;
         hd_addr_q   <= '0;
         imem_addr_q <= '0;
         imem_data_q <= '0;
         imem_we_q   <= 1'b0;
         cpu_hold_q  <= 1'b1;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         len_err_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         state_q     <= state_d;
         n_q         <= n_d;
         base_q      <= base_d;
         rd_idx_q    <= rd_idx_d;
         v1_q        <= v1_d;
         v2_q        <= v2_d;
         idx1_q      <= idx1_d;
         idx2_q      <= idx2_d;
         hd_addr_q   <= hd_addr_d;
         imem_addr_q <= imem_addr_d;
         imem_data_q <= imem_data_d;
         imem_we_q   <= imem_we_d;
         cpu_hold_q  <= cpu_hold_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         len_err_q   <= len_err_d;
`ifdef BOOT_CHECKSUM_EN
         csum_q      <= csum_d;
`endif
      end
   end

   always_comb begin
      state_d     = state_q;
      n_d         = n_q;
      base_d      = base_q;
      rd_idx_d    = rd_idx_q;
      v1_d        = 1'b0;
      idx1_d      = idx1_q;
      // Second stage aligns with the two-edge HD read latency.
      v2_d        = v1_q;
      idx2_d      = idx1_q;
      hd_addr_d   = hd_addr_q;
      imem_addr_d = imem_addr_q;
      imem_data_d = imem_data_q;
      imem_we_d   = 1'b0;
      cpu_hold_d  = cpu_hold_q;
      busy_d      = busy_q;
      done_d      = 1'b0;
      len_err_d   = len_err_q;
`ifdef BOOT_CHECKSUM_EN
      csum_d      = csum_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               n_d        = n_sel;
               base_d     = src_base;
               len_err_d  = too_long;
               cpu_hold_d = 1'b1;
               busy_d     = 1'b1;
`ifdef BOOT_CHECKSUM_EN
               csum_d     = '0;
`endif
               if (n_sel == '0) begin
                  state_d = S_FINISH;
               end else begin
                  hd_addr_d = src_base;
                  rd_idx_d  = ONE_A;
                  v1_d      = 1'b1;
                  idx1_d    = '0;
                  state_d   = S_STREAM;
               end
            end
         end
         S_STREAM: begin
            if (rd_idx_q < n_q) begin
               hd_addr_d = base_q + rd_idx_q;
               rd_idx_d  = rd_idx_q + ONE_A;
               v1_d      = 1'b1;
               idx1_d    = rd_idx_q;
            end
            if (v2_q) begin
               imem_we_d   = 1'b1;
               imem_addr_d = BASE_A + idx2_q;
               imem_data_d = hd_data;
`ifdef BOOT_CHECKSUM_EN
               csum_d      = csum_q + hd_data;
`endif
               if (idx2_q == n_q - ONE_A) begin
                  state_d = S_FINISH;
               end
            end
         end
         S_FINISH: begin
            done_d     = 1'b1;
            busy_d     = 1'b0;
            cpu_hold_d = 1'b0;
            state_d    = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   assign hd_addr   = hd_addr_q;
   assign imem_addr = imem_addr_q;
   assign imem_data = imem_data_q;
   assign imem_we   = imem_we_q;
   assign cpu_hold  = cpu_hold_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign len_err   = len_err_q;
`ifdef BOOT_CHECKSUM_EN
   assign checksum  = csum_q;
`endif

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Table-driven bench for boot_loader_ctrl with a write scoreboard and a registered HD model.
module tb_boot_loader_ctrl;

   logic        clk_auto = 1'b0;
   logic        reset;
   logic        start;
   logic [31:0] src_base;
   logic [31:0] word_count;
   logic [31:0] hd_addr;
   logic [31:0] hd_data;
   logic [31:0] imem_addr;
   logic [31:0] imem_data;
   logic        imem_we;
   logic        cpu_hold;
   logic        busy;
   logic        done;
   logic        len_err;
`ifdef BOOT_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   int checks = 0;
   int errors = 0;

   always #5 clk_auto = ~clk_auto;

   boot_loader_ctrl dut (
      .clk_auto   (clk_auto),
      .reset      (reset),
      .start      (start),
      .src_base   (src_base),
      .word_count (word_count),
      .hd_addr    (hd_addr),
      .hd_data    (hd_data),
      .imem_addr  (imem_addr),
      .imem_data  (imem_data),
      .imem_we    (imem_we),
`ifdef BOOT_CHECKSUM_EN
      .checksum   (checksum),
`endif
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .len_err    (len_err)
   );

   function automatic logic [31:0] hd_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
   endfunction

   // Registered read: data for the address set at edge E is sampled by the DUT at E+2.
   always @(posedge clk_auto) hd_data <= hd_word(hd_addr);

   typedef struct {
      logic [31:0] src;
      logic [31:0] wc;
      int          n;
      bit          lerr;
      int          restart_at;
      bit          hold;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   vec_t vecs[10];
   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; drives start, runs until done (or the cycle budget), and checks the load.
   task automatic run_load(input vec_t v, input int id);
      int          d_exp;
      int          done_cyc;
      logic [31:0] sum;
      exp_t        e;
      d_exp    = (v.n == 0) ? 1 : v.n + 2;
      done_cyc = -1;
      sum      = 32'h0;
      start      = 1'b1;
      src_base   = v.src;
      word_count = v.wc;
      for (int i = 0; i < v.n; i++) begin
         e.addr = 32'(i);
         e.data = hd_word(v.src + 32'(i));
         e.cyc  = i + 2;
         sum    = sum + e.data;
         sb.push_back(e);
      end
      @(posedge clk_auto);
      @(negedge clk_auto);
      chk("c0_cpu_hold", {63'd0, cpu_hold}, 64'd1);
      chk("c0_busy", {63'd0, busy}, 64'd1);
      chk("c0_done", {63'd0, done}, 64'd0);
      chk("c0_len_err", {63'd0, len_err}, {63'd0, v.lerr});
      if (v.n > 0) chk("c0_hd_addr", {32'd0, hd_addr}, {32'd0, v.src});
      if (!v.hold) start = 1'b0;
      for (int cyc = 1; cyc <= d_exp + 4; cyc++) begin
         @(posedge clk_auto);
         @(negedge clk_auto);
         if (imem_we) begin
            if (sb.size() == 0) begin
               chk("extra_write", 64'd1, 64'd0);
            end else begin
               e = sb.pop_front();
               chk("wr_addr", {32'd0, imem_addr}, {32'd0, e.addr});
               chk("wr_data", {32'd0, imem_data}, {32'd0, e.data});
               chk("wr_cycle", 64'(cyc), 64'(e.cyc));
            end
         end
         if (cyc < v.n) chk("hd_addr", {32'd0, hd_addr}, {32'd0, v.src + 32'(cyc)});
         if (v.restart_at != 0 && cyc == v.restart_at - 1) begin
            start      = 1'b1;
            src_base   = 32'hDEAD0000;
            word_count = 32'd7;
         end
         if (v.restart_at != 0 && cyc == v.restart_at) begin
            start      = v.hold;
            src_base   = v.src;
            word_count = v.wc;
         end
         if (done) begin
            done_cyc = cyc;
            break;
         end
      end
      chk("done_cycle", 64'(done_cyc), 64'(d_exp));
      chk("missing_writes", 64'(sb.size()), 64'd0);
      sb.delete();
      chk("end_cpu_hold", {63'd0, cpu_hold}, 64'd0);
      chk("end_busy", {63'd0, busy}, 64'd0);
      chk("end_len_err", {63'd0, len_err}, {63'd0, v.lerr});
`ifdef BOOT_CHECKSUM_EN
      chk("checksum", {32'd0, checksum}, {32'd0, sum});
`endif
      $display("load %0d: src=%08h wc=%0d n=%0d done_cycle=%0d", id, v.src, v.wc, v.n, done_cyc);
   endtask

   vec_t vr;
   int   wr_after;

   initial begin
      vecs[0] = '{32'h10,       32'd4,   4,  1'b0, 0, 1'b0};
      vecs[1] = '{32'h20,       32'd0,   0,  1'b0, 0, 1'b0};
      vecs[2] = '{32'h100,      32'd100, 64, 1'b1, 0, 1'b0};
      vecs[3] = '{32'h40,       32'd1,   1,  1'b0, 0, 1'b0};
      vecs[4] = '{32'hFFFFFFFE, 32'd3,   3,  1'b0, 0, 1'b0};
      vecs[5] = '{32'h10,       32'd4,   4,  1'b0, 3, 1'b0};
      vecs[6] = '{32'h50,       32'd5,   5,  1'b0, 0, 1'b1};
      vecs[7] = '{32'h60,       32'd2,   2,  1'b0, 0, 1'b0};
      vecs[8] = '{32'h70,       32'd64,  64, 1'b0, 0, 1'b0};
      vecs[9] = '{32'h80,       32'd65,  64, 1'b1, 0, 1'b0};

      reset = 1'b1; start = 1'b0; src_base = '0; word_count = '0;
      repeat (3) @(negedge clk_auto);
      chk("rst_hd_addr", {32'd0, hd_addr}, 64'd0);
      chk("rst_imem_addr", {32'd0, imem_addr}, 64'd0);
      chk("rst_imem_data", {32'd0, imem_data}, 64'd0);
      chk("rst_imem_we", {63'd0, imem_we}, 64'd0);
      chk("rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_done", {63'd0, done}, 64'd0);
      chk("rst_len_err", {63'd0, len_err}, 64'd0);
      reset = 1'b0;
      repeat (3) @(negedge clk_auto);
      chk("idle_cpu_hold", {63'd0, cpu_hold}, 64'd1);
      $display("reset: cpu_hold=%0b busy=%0b", cpu_hold, busy);

      for (int k = 0; k < 10; k++) run_load(vecs[k], k);
      start = 1'b0;
      repeat (2) @(negedge clk_auto);

      // Asynchronous reset in the middle of a 4-word load.
      start = 1'b1; src_base = 32'h200; word_count = 32'd4;
      @(posedge clk_auto);
      @(negedge clk_auto);
      start = 1'b0;
      repeat (3) @(posedge clk_auto);
      #1;
      chk("pre_rst_we", {63'd0, imem_we}, 64'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_we", {63'd0, imem_we}, 64'd0);
      chk("mid_rst_cpu_hold", {63'd0, cpu_hold}, 64'd1);
      chk("mid_rst_busy", {63'd0, busy}, 64'd0);
      @(negedge clk_auto);
      @(negedge clk_auto);
      reset = 1'b0;
      wr_after = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk_auto);
         if (imem_we) wr_after++;
      end
      chk("writes_after_rst", 64'(wr_after), 64'd0);
      $display("mid-load reset: writes after reset=%0d", wr_after);

      vr = '{32'h300, 32'd2, 2, 1'b0, 0, 1'b0};
      run_load(vr, 10);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
